// File: rtl/seq_gen_core_sc_if.sv
// Byte-wide register/RAM bus used to configure the sequence generator and load its pattern.
// Read data returns one clock after the read strobe.
interface seq_gen_core_sc_if #(
    parameter int ABUSWIDTH = 16
);
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_IN;
    logic                 BUS_RD;
    logic                 BUS_WR;
    logic [7:0]           BUS_DATA_OUT;

    modport master (
        output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
        input  BUS_DATA_OUT
    );

    modport slave (
        input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
        output BUS_DATA_OUT
    );
endinterface

// File: rtl/seq_gen_core_sc.sv
// Pattern sequence generator: firmware loads a pattern over the byte bus and the sequencer
// replays it on SEQ_OUT one word per clock, optionally repeated with idle gaps between passes.
module seq_gen_core_sc #(
    parameter int MEM_BYTES = 8*1024,
    parameter int ABUSWIDTH = 16,
    parameter int OUT_BITS  = 8
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    seq_gen_core_sc_if.slave    bus,
    input  logic                SEQ_EXT_START,
    output logic [OUT_BITS-1:0] SEQ_OUT,
    output logic                SEQ_BUSY
);
    localparam int BPW       = OUT_BITS / 8;
    localparam int MEM_WORDS = MEM_BYTES / BPW;
    localparam int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int LW        = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} state_t;

    // A pass can never be longer than the RAM holds.
    function automatic logic [15:0] clamp_count(input logic [15:0] c);
        return (32'(c) > 32'(MEM_WORDS)) ? 16'(MEM_WORDS) : c;
    endfunction

    logic [OUT_BITS-1:0] mem [MEM_WORDS];

    logic [31:0]   add_ext, ram_off, boff;
    logic [AW-1:0] ram_widx;
    logic [3:0]    reg_idx;
    logic          is_reg, is_ram, wr_reg, wr_ram, start_wr;

    logic          soft_rst_p0, conf_en;
    logic [15:0]   count_r, repeat_r, wait_r;

    state_t        state_p0;
    logic [15:0]   ptr_p0, pass_p0, wait_cnt_p0, ec_lat, rep_lat, wait_lat;
    logic [15:0]   ec_now;
    logic          ext_trig, trig;

    logic [OUT_BITS-1:0] seq_word_p1, bus_word_p1;
    logic          vld_p1, done_r;
    logic          rd_ram_p1, rd_reg_p1;
    logic [3:0]    rd_idx_p1;
    logic [LW-1:0] rd_boff_p1;
    logic [7:0]    rd_byte;

    always_comb begin
        add_ext  = 32'(bus.BUS_ADD);
        ram_off  = add_ext - 32'd16;
        boff     = ram_off % 32'(BPW);
        ram_widx = AW'(ram_off / 32'(BPW));
        is_reg   = add_ext < 32'd16;
        is_ram   = !is_reg && (ram_off < 32'(MEM_BYTES));
        reg_idx  = bus.BUS_ADD[3:0];
        wr_reg   = bus.BUS_WR && is_reg;
        wr_ram   = bus.BUS_WR && is_ram;
        start_wr = wr_reg && (reg_idx == 4'd1);
    end

    // Configuration registers; a write to address 0 resets everything one clock later.
    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            soft_rst_p0 <= 1'b0;
            conf_en     <= 1'b0;
            count_r     <= 16'(MEM_WORDS);
            repeat_r    <= 16'd1;
            wait_r      <= 16'd0;
        end else begin
            soft_rst_p0 <= wr_reg && (reg_idx == 4'd0);
            if (soft_rst_p0) begin
                conf_en  <= 1'b0;
                count_r  <= 16'(MEM_WORDS);
                repeat_r <= 16'd1;
                wait_r   <= 16'd0;
            end else if (wr_reg) begin
                case (reg_idx)
                    4'd2: conf_en        <= bus.BUS_DATA_IN[0];
                    4'd3: count_r[7:0]   <= bus.BUS_DATA_IN;
                    4'd4: count_r[15:8]  <= bus.BUS_DATA_IN;
                    4'd5: repeat_r[7:0]  <= bus.BUS_DATA_IN;
                    4'd6: repeat_r[15:8] <= bus.BUS_DATA_IN;
                    4'd7: wait_r[7:0]    <= bus.BUS_DATA_IN;
                    4'd8: wait_r[15:8]   <= bus.BUS_DATA_IN;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ec_now   = clamp_count(count_r);
        ext_trig = conf_en && SEQ_EXT_START && (state_p0 == ST_IDLE) && !SEQ_BUSY;
        trig     = (start_wr || ext_trig) && (ec_now != 16'd0);
    end

    // Stage p0: sequencer FSM issues the word pointer to the RAM.
    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            state_p0    <= ST_IDLE;
            ptr_p0      <= 16'd0;
            pass_p0     <= 16'd0;
            wait_cnt_p0 <= 16'd0;
            ec_lat      <= 16'd0;
            rep_lat     <= 16'd0;
            wait_lat    <= 16'd0;
        end else if (soft_rst_p0) begin
            state_p0    <= ST_IDLE;
            ptr_p0      <= 16'd0;
            pass_p0     <= 16'd0;
            wait_cnt_p0 <= 16'd0;
        end else if (trig) begin
            state_p0 <= ST_RUN;
            ptr_p0   <= 16'd0;
            pass_p0  <= repeat_r;
            ec_lat   <= ec_now;
            rep_lat  <= repeat_r;
            wait_lat <= wait_r;
        end else begin
            case (state_p0)
                ST_RUN: begin
                    if (ptr_p0 == ec_lat - 16'd1) begin
                        if (rep_lat != 16'd0 && pass_p0 == 16'd1) begin
                            state_p0 <= ST_IDLE;
                        end else begin
                            if (rep_lat != 16'd0) pass_p0 <= pass_p0 - 16'd1;
                            ptr_p0 <= 16'd0;
                            if (wait_lat != 16'd0) begin
                                state_p0    <= ST_WAIT;
                                wait_cnt_p0 <= wait_lat;
                            end
                        end
                    end else begin
                        ptr_p0 <= ptr_p0 + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_p0 == 16'd1) state_p0 <= ST_RUN;
                    else wait_cnt_p0 <= wait_cnt_p0 - 16'd1;
                end
                default: state_p0 <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: synchronous RAM reads for sequencer and bus; the sequencer sees pre-write data.
    always_ff @(posedge BUS_CLK) begin
        if (wr_ram) begin
            for (int b = 0; b < BPW; b++)
                if (boff == 32'(BPW - 1 - b)) mem[ram_widx][8*b +: 8] <= bus.BUS_DATA_IN;
        end
        seq_word_p1 <= mem[ptr_p0[AW-1:0]];
        if (bus.BUS_RD) bus_word_p1 <= mem[ram_widx];
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            rd_ram_p1  <= 1'b0;
            rd_reg_p1  <= 1'b0;
            rd_idx_p1  <= 4'd0;
            rd_boff_p1 <= '0;
        end else if (soft_rst_p0) begin
            rd_ram_p1  <= 1'b0;
            rd_reg_p1  <= 1'b0;
            rd_idx_p1  <= 4'd0;
            rd_boff_p1 <= '0;
        end else if (bus.BUS_RD) begin
            rd_ram_p1  <= is_ram;
            rd_reg_p1  <= is_reg;
            rd_idx_p1  <= reg_idx;
            rd_boff_p1 <= LW'(boff);
        end
    end

    // Stage p2: registered pattern output; busy stays high until the last word has left the pipe.
    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            vld_p1   <= 1'b0;
            SEQ_OUT  <= '0;
            SEQ_BUSY <= 1'b0;
            done_r   <= 1'b1;
        end else if (soft_rst_p0) begin
            vld_p1   <= 1'b0;
            SEQ_OUT  <= '0;
            SEQ_BUSY <= 1'b0;
            done_r   <= 1'b1;
        end else begin
            vld_p1   <= (state_p0 == ST_RUN);
            if (vld_p1) SEQ_OUT <= seq_word_p1;
            SEQ_BUSY <= (state_p0 != ST_IDLE) || vld_p1;
            done_r   <= trig ? 1'b0 : !((state_p0 != ST_IDLE) || vld_p1);
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (rd_ram_p1) begin
            for (int b = 0; b < BPW; b++)
                if (32'(rd_boff_p1) == 32'(BPW - 1 - b)) rd_byte = bus_word_p1[8*b +: 8];
        end else if (rd_reg_p1) begin
            case (rd_idx_p1)
                4'd1:    rd_byte = {6'b0, SEQ_BUSY, done_r};
                4'd2:    rd_byte = {7'b0, conf_en};
                4'd3:    rd_byte = count_r[7:0];
                4'd4:    rd_byte = count_r[15:8];
                4'd5:    rd_byte = repeat_r[7:0];
                4'd6:    rd_byte = repeat_r[15:8];
                4'd7:    rd_byte = wait_r[7:0];
                4'd8:    rd_byte = wait_r[15:8];
                default: rd_byte = 8'h00;
            endcase
        end
    end

    assign bus.BUS_DATA_OUT = rd_byte;

endmodule
